// File: rtl/serial_adder_pkg.sv
// serial_adder shared types.
// Controller state encoding for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder request/result bundle.
// master drives the operation, slave reports status and results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start,
    output sub,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  sum,
    input  cout,
    input  overflow
  );

  modport slave (
    input  start,
    input  sub,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output sum,
    output cout,
    output overflow
  );

endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: DIGIT-bit ripple of full-adder cells.
// c_msb is the carry into the top cell, used for signed overflow.
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) |
               (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add/sub, DIGIT bits per clock.
// Start/busy/done handshake with registered results.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must divide WIDTH");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cm;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sr_nx;
  logic             last;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_dig (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .ci    (c_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cm)
  );

  // Single-digit configuration has nothing left to shift.
  generate
    if (DIGIT == WIDTH) begin : g_one
      assign a_sh  = '0;
      assign b_sh  = '0;
      assign sr_nx = dig_s;
    end else begin : g_multi
      assign a_sh  = {{DIGIT{1'b0}},
                      a_q[WIDTH-1:DIGIT]};
      assign b_sh  = {{DIGIT{1'b0}},
                      b_q[WIDTH-1:DIGIT]};
      assign sr_nx = {dig_s,
                      sr_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_sh;
        b_d   = b_sh;
        sr_d  = sr_nx;
        c_d   = dig_co;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          sum_d   = sr_nx;
          cout_d  = dig_co;
          ovf_d   = dig_co ^ dig_cm;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle binary adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock, using a ripple of full-adder cells per digit and a registered carry between digits. It generalises the single-bit full adder into a width/throughput-configurable arithmetic unit with a start/busy/done handshake, subtraction mode and signed-overflow detection. It serves as the shared arithmetic primitive for later datapath labs where area matters more than single-cycle latency.

## Interface
- WIDTH, 8: operand/result width in bits.
- DIGIT, 2: bits added per cycle; must divide WIDTH exactly, otherwise elaboration fails.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = a + b + cin, 1 = a − b (cin ignored).
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cin  input  1  carry-in for add mode.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid and updated.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in sub mode 1 = no borrow.
- overflow  output  1  two's-complement overflow of the result.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- FSM states: IDLE, RUN.
  - IDLE: start=1 → latch a, b' = sub ? ~b : b, carry = sub ? 1 : cin, digit counter = 0, go RUN.
  - RUN: each cycle add low DIGIT bits of a and b' plus carry, shift result digit into the top of the sum shift register, shift a and b' right by DIGIT, update carry, increment counter. On the final digit (counter = N−1): update sum, cout, overflow, pulse done, return to IDLE.
- overflow = carry into MSB XOR carry out of MSB, both taken from the final digit.
- start while busy is ignored; latched operands are unaffected.
- a, b, cin, sub are only sampled on the accepting edge; later changes have no effect.
- sum, cout, overflow hold their last value until the next completion; they never show partial results.
- Reset (any state, including mid-RUN): IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, counter=0, internal shift registers cleared; no done for the aborted operation.

## Timing
- Edge E0 samples start=1 in IDLE → busy=1 after E0.
- Digits processed on edges E1..EN; after EN: done=1, busy=0, results valid.
- Latency: done asserted N cycles after the accepting edge; throughput one operation per N+1 cycles minimum.
- done high for exactly one cycle. start=1 during the done cycle is accepted at the next edge (back-to-back).
- All outputs are registered; no combinational path from inputs to outputs.
- Reset has priority over start on the same edge.

## Structure
- serial_adder_pkg: state enum typedef (IDLE, RUN); no other shared constants.
- Sub-module digit_adder (parameter DIGIT): combinational chain of DIGIT full-adder cells; inputs x, y, ci; outputs s, co, and c_msb (carry into the top cell) for overflow.
- serial_adder: FSM, counter of width $clog2(N) (minimum 1), operand/sum shift registers, carry register, output registers.

## Test plan
(WIDTH=8, DIGIT=2, N=4 unless noted)
- Add: a=8'h3C, b=8'h0F, cin=0, sub=0 → after 4 cycles done=1, sum=8'h4B, cout=0, overflow=0; busy high for exactly 4 cycles.
- Carry/cin: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, overflow=0; then a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1.
- Signed overflow: a=8'h7F, b=8'h01 add → sum=8'h80, cout=0, overflow=1; sub a=8'h80, b=8'h01 → sum=8'h7F, cout=1, overflow=1; sub a=8'h05, b=8'h07 → sum=8'hFE, cout=0, overflow=0.
- Handshake: start held high with new operands in every busy cycle → ignored, first result reported; start in done cycle → second operation completes 4 cycles later, no idle gap.
- Reset mid-op: rst=1 on the second RUN edge → next cycle busy=0, done=0, sum=0, cout=0, overflow=0; no stray done; subsequent op a=8'h12, b=8'h34 → sum=8'h46.
- Parameter sweep: DIGIT ∈ {1, 4, 8} with WIDTH=8, random operands vs reference model (1000 ops each) → results match, done after 8/2/1 cycles respectively.
